// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundles the pipeline, multi-cycle and register-file write-port
// signals; slave is the arbiter side, master the driving environment.
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_data;
    logic              mc_valid;
    logic              mc_ready;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_req;
    logic              pending;
    modport slave (
        input  pipe_valid, pipe_addr, pipe_data, mc_valid, mc_addr, mc_data,
        output mc_ready, rf_we, rf_waddr, rf_wdata, stall_req, pending
    );
    modport master (
        output pipe_valid, pipe_addr, pipe_data, mc_valid, mc_addr, mc_data,
        input  mc_ready, rf_we, rf_waddr, rf_wdata, stall_req, pending
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline write-back and a FIFO-buffered multi-cycle unit.
// Define WBARB_STARVE_GUARD_EN to build the age counter that stalls the pipeline for a starved FIFO head.
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    if (!(DEPTH == 2 || DEPTH == 4) || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_cfg
        $error("wb_port_arbiter: DEPTH must be 2 or 4 and STARVE_LIMIT 1..15");
    end
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic              pipe_req, push, pop, pipe_win, head_live;
    assign pipe_req    = bus.pipe_valid & |bus.pipe_addr;
    assign bus.pending = |count;
    assign bus.mc_ready = count != (PW+1)'(DEPTH);
    assign push        = bus.mc_valid & bus.mc_ready;
    assign pop         = bus.pending & (bus.stall_req | !pipe_req);
    assign pipe_win    = !bus.stall_req & pipe_req;
    assign head_live   = |addr_mem[head];
`ifdef WBARB_STARVE_GUARD_EN
    logic [3:0] age;
    assign bus.stall_req = (age == 4'(STARVE_LIMIT)) & bus.pending;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) age <= '0;
        else if (pop) age <= '0;
        else if (bus.pending && age != 4'(STARVE_LIMIT)) age <= age + 4'd1;
    end
`else
    assign bus.stall_req = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= bus.mc_addr;
            data_mem[tail] <= bus.mc_data;
        end
    end
    // Popped entries addressed to r0 are dropped without touching the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count     <= count + (PW+1)'(push) - (PW+1)'(pop);
            bus.rf_we <= pipe_win | (pop & head_live);
            if (pipe_win) begin
                bus.rf_waddr <= bus.pipe_addr;
                bus.rf_wdata <= bus.pipe_data;
            end else if (pop & head_live) begin
                bus.rf_waddr <= addr_mem[head];
                bus.rf_wdata <= data_mem[head];
            end
        end
    end
endmodule
